// File: rtl/spi_lcd_byte_sequencer.sv
// Feeds the LCD SPI phy one byte per frame, merging a command FIFO with an RGB565 pixel stream.
// A byte is presented one cycle after a choice is made; each byte commits on the first masterClk after a dataClk rise.
module spi_lcd_byte_sequencer #(
   parameter int FIFO_AW = 4,
   parameter int CNT_W   = 16
) (
   input  logic               masterClk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               wr_cmd,
   input  logic [7:0]         wr_data,
   output logic               fifo_full,
   output logic [FIFO_AW:0]   fifo_level,
   input  logic               px_valid,
   input  logic [15:0]        px_data,
   output logic               px_ready,
   input  logic               dataClk,
   output logic [7:0]         outputData,
   output logic               enableSPI,
   output logic               enableCS,
   output logic               enableDC,
   output logic               busy,
   output logic [CNT_W-1:0]   bytes_sent,
   input  logic               cnt_clr
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, SEND_F, SEND_PH, SEND_PL} state_t;

   state_t               state;
   logic [8:0]           mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic                 dc_q;
   logic [7:0]           px_lo;
   logic                 rise;
   logic                 fifo_empty;
   logic                 wr_ok;
   logic                 take_next;
   logic                 pick_fifo;
   logic                 pick_px;

   assign rise       = dataClk & ~dc_q;
   assign fifo_empty = (fifo_level == '0);
   assign fifo_full  = (fifo_level == LVL_FULL);
   assign wr_ok      = wr_en & ~fifo_full;
   assign busy       = (state != IDLE);

   // A new source is chosen when idle, or on a commit that is not a pixel high byte.
   assign take_next = (state == IDLE) || (rise && (state != SEND_PH));
   assign pick_fifo = take_next & ~fifo_empty;
   assign pick_px   = take_next & fifo_empty & px_valid;
   assign px_ready  = pick_px & ~rst;

   always_ff @(posedge masterClk) begin
      if (wr_ok) mem[wr_ptr] <= {wr_cmd, wr_data};
   end

   always_ff @(posedge masterClk) begin
      if (rst) begin
         state      <= IDLE;
         dc_q       <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         px_lo      <= '0;
         outputData <= '0;
         enableSPI  <= 1'b0;
         enableCS   <= 1'b0;
         enableDC   <= 1'b0;
         bytes_sent <= '0;
      end else begin
         dc_q <= dataClk;

         if (wr_ok)     wr_ptr <= wr_ptr + PTR_ONE;
         if (pick_fifo) rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_ok && !pick_fifo)      fifo_level <= fifo_level + LVL_ONE;
         else if (!wr_ok && pick_fifo) fifo_level <= fifo_level - LVL_ONE;

         if (cnt_clr)                        bytes_sent <= '0;
         else if (rise && (state != IDLE))   bytes_sent <= bytes_sent + CNT_ONE;

         if ((state == SEND_PH) && rise) begin
            outputData <= px_lo;
            enableDC   <= 1'b0;
            state      <= SEND_PL;
         end else if (pick_fifo) begin
            outputData <= mem[rd_ptr][7:0];
            enableDC   <= mem[rd_ptr][8];
            enableSPI  <= 1'b1;
            enableCS   <= 1'b1;
            state      <= SEND_F;
         end else if (pick_px) begin
            outputData <= px_data[15:8];
            px_lo      <= px_data[7:0];
            enableDC   <= 1'b0;
            enableSPI  <= 1'b1;
            enableCS   <= 1'b1;
            state      <= SEND_PH;
         end else if (take_next) begin
            // outputData is left alone; the phy already holds the last byte.
            enableSPI  <= 1'b0;
            enableCS   <= 1'b0;
            enableDC   <= 1'b0;
            state      <= IDLE;
         end
      end
   end

endmodule
